// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for X^E mod M.
// Drives an external Montgomery multiplier over a start/done handshake.
module mont_exp_ctrl #(
    parameter int N      = 512,
    parameter int E_BITS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_r,
    input  logic [N-1:0]      in_r2,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              busy,
    output logic              mm_start,
    output logic [N-1:0]      mm_a,
    output logic [N-1:0]      mm_b,
    output logic [N-1:0]      mm_m,
    input  logic [N-1:0]      mm_result,
    input  logic              mm_done
);
    localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [IW-1:0] I_TOP = IW'(E_BITS - 1);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_X,
        S_SQUARE,
        S_MULT,
        S_CONV_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_wait;
    logic [E_BITS-1:0] r_e;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_xt;
    logic [IW-1:0]     r_i;
    logic [N-1:0]      r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_mm_start;
    logic [N-1:0]      r_mm_a;
    logic [N-1:0]      r_mm_b;
    logic [N-1:0]      r_mm_m;

    logic w_cap;
    logic w_last;
    logic w_bit;

    // Completions are only honoured in the WAIT phase of an operation.
    assign w_cap  = r_wait & mm_done;
    assign w_last = (r_i == '0);
    assign w_bit  = r_e[r_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait     <= 1'b0;
            r_e        <= '0;
            r_a        <= '0;
            r_xt       <= '0;
            r_i        <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_e        <= in_e;
                        r_a        <= in_r;
                        r_i        <= I_TOP;
                        r_busy     <= 1'b1;
                        r_wait     <= 1'b0;
                        r_mm_start <= 1'b1;
                        r_mm_a     <= in_x;
                        r_mm_b     <= in_r2;
                        r_mm_m     <= in_m;
                        r_state    <= S_CONV_X;
                    end
                end
                S_CONV_X: begin
                    if (w_cap) begin
                        r_xt       <= mm_result;
                        r_wait     <= 1'b0;
                        r_mm_start <= 1'b1;
                        r_mm_a     <= r_a;
                        r_mm_b     <= r_a;
                        r_state    <= S_SQUARE;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_SQUARE: begin
                    if (w_cap) begin
                        r_a        <= mm_result;
                        r_wait     <= 1'b0;
                        r_mm_start <= 1'b1;
                        r_mm_a     <= mm_result;
                        if (w_bit) begin
                            r_mm_b  <= r_xt;
                            r_state <= S_MULT;
                        end else if (w_last) begin
                            r_mm_b  <= ONE;
                            r_state <= S_CONV_OUT;
                        end else begin
                            r_mm_b  <= mm_result;
                            r_i     <= r_i - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_MULT: begin
                    if (w_cap) begin
                        r_a        <= mm_result;
                        r_wait     <= 1'b0;
                        r_mm_start <= 1'b1;
                        r_mm_a     <= mm_result;
                        if (w_last) begin
                            r_mm_b  <= ONE;
                            r_state <= S_CONV_OUT;
                        end else begin
                            r_mm_b  <= mm_result;
                            r_i     <= r_i - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_CONV_OUT: begin
                    if (w_cap) begin
                        r_a      <= mm_result;
                        r_result <= mm_result;
                        r_done   <= 1'b1;
                        r_wait   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = r_busy;
    assign mm_start = r_mm_start;
    assign mm_a     = r_mm_a;
    assign mm_b     = r_mm_b;
    assign mm_m     = r_mm_m;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery
// multiplier and a plain modular-power reference.
module tb_mont_exp_ctrl;
    localparam int N  = 8;
    localparam int EB = 8;
    localparam int M  = 239;
    localparam int RM = 17;
    localparam int R2 = 50;

    typedef struct {
        int res;
        int ops;
        int lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] in_x = '0;
    logic [EB-1:0] in_e = '0;
    logic [N-1:0] in_m = 8'(M);
    logic [N-1:0] in_r = 8'(RM);
    logic [N-1:0] in_r2 = 8'(R2);
    logic [N-1:0] result;
    logic         done;
    logic         busy;
    logic         mm_start;
    logic [N-1:0] mm_a;
    logic [N-1:0] mm_b;
    logic [N-1:0] mm_m;
    logic [N-1:0] mm_result = '0;
    logic         mm_done = 1'b0;

    int  checks = 0;
    int  errors = 0;
    int  n_done = 0;
    int  cyc = 0;
    bit  allow_spur = 1'b0;
    bit  rand_lat = 1'b0;
    int  fix_lat = 3;
    exp_t q[$];

    mont_exp_ctrl #(.N(N), .E_BITS(EB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m),
        .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    function automatic int modpow(input int x, input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = (r * x) % M;
        return r;
    endfunction

    function automatic int popc(input int e);
        int c = 0;
        for (int k = 0; k < EB; k++) c += (e >> k) & 1;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Montgomery multiplier model: done arrives L cycles after the issue cycle.
    initial begin : mm_model
        int cnt;
        int rinv;
        bit pend;
        bit stable;
        logic [N-1:0] la;
        logic [N-1:0] lb;
        logic [N-1:0] lm;
        rinv = 0;
        for (int k = 1; k < M; k++) if ((RM * k) % M == 1) rinv = k;
        pend = 1'b0;
        stable = 1'b1;
        cnt = 0;
        la = '0;
        lb = '0;
        lm = '0;
        forever begin
            @(posedge clk);
            #1;
            mm_done = 1'b0;
            if (reset) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (mm_a !== la || mm_b !== lb || mm_m !== lm) stable = 1'b0;
                if (mm_start) chk("mm_start_during_wait", 32'(mm_start), 32'd0);
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    mm_done = 1'b1;
                    mm_result = 8'((int'(la) * int'(lb) * rinv) % M);
                    chk("operands_stable", 32'(stable), 32'd1);
                end
            end else if (mm_start) begin
                la = mm_a;
                lb = mm_b;
                lm = mm_m;
                stable = 1'b1;
                pend = 1'b1;
                cnt = rand_lat ? int'($urandom_range(1, 20)) : fix_lat;
                chk("mm_m_is_modulus", 32'(mm_m), 32'(M));
            end else if (allow_spur && $urandom_range(0, 3) == 0) begin
                mm_done = 1'b1;
                mm_result = 8'($urandom);
            end
        end
    end

    initial begin : monitor
        bit pm = 1'b0;
        bit pb = 1'b0;
        bit chkb = 1'b0;
        int first = 0;
        int ops = 0;
        exp_t ex;
        forever begin
            @(negedge clk);
            cyc++;
            if (mm_start) begin
                chk("mm_start_not_back_to_back", 32'(pm), 32'd0);
                ops++;
            end
            if (busy && !pb) first = cyc;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    ex = q.pop_front();
                    chk("result", 32'(result), 32'(ex.res));
                    chk("mm_ops", 32'(ops), 32'(ex.ops));
                    if (ex.lat >= 0) chk("latency", 32'(cyc - first + 2), 32'(ex.lat));
                end
                ops = 0;
                n_done++;
                chkb = 1'b1;
            end else if (chkb) begin
                chkb = 1'b0;
                chk("busy_drops_after_done", 32'(busy), 32'd0);
            end
            if (!busy) ops = 0;
            pm = mm_start;
            pb = busy;
        end
    end

    task automatic issue(input int x, input int e, input bit push);
        int ops;
        int lat;
        ops = EB + popc(e) + 2;
        lat = rand_lat ? -1 : 2 + ops * (fix_lat + 1);
        @(negedge clk);
        allow_spur = 1'b0;
        @(negedge clk);
        in_x = 8'(x);
        in_e = 8'(e);
        start = 1'b1;
        if (push) q.push_back('{modpow(x, e), ops, lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k = 0;
        while (n_done == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 32'(n_done != n0), 32'd1);
        if (n_done == n0) begin
            reset = 1'b1;
            q.delete();
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin : stim
        int n0;
        int x;
        int e;
        repeat (2) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mm_start", 32'(mm_start), 32'd0);
        chk("rst_mm_ops", {8'd0, mm_a, mm_b, mm_m}, 32'd0);
        reset = 1'b0;

        n0 = n_done;
        issue(5, 13, 1'b1);
        wait_done(n0, 2000);
        n0 = n_done;
        issue(5, 0, 1'b1);
        wait_done(n0, 2000);
        n0 = n_done;
        issue(5, 1, 1'b1);
        wait_done(n0, 2000);

        // Starts while busy must not disturb the running job.
        n0 = n_done;
        issue(5, 3, 1'b1);
        repeat (3) @(negedge clk);
        in_x = 8'd7;
        in_e = 8'hff;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0, 2000);
        chk("result_held", 32'(result), 32'd125);

        issue(5, 13, 1'b0);
        repeat (28) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mm_start", 32'(mm_start), 32'd0);
        chk("abort_mm_ops", {8'd0, mm_a, mm_b, mm_m}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n0 = n_done;
        issue(2, 8, 1'b1);
        wait_done(n0, 2000);

        rand_lat = 1'b1;
        for (int t = 0; t < 200; t++) begin
            allow_spur = 1'b1;
            repeat ($urandom_range(2, 6)) @(negedge clk);
            x = int'($urandom_range(0, M - 1));
            e = int'($urandom_range(0, 255));
            n0 = n_done;
            issue(x, e, 1'b1);
            wait_done(n0, 3000);
        end
        allow_spur = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
